forward_ctrl: RTL and testbench
===============================

# forward_ctrl

Forwarding and load-use hazard controller for the EX stage of the 5-stage MIPS pipeline. It tracks destination-register information for the instructions in EX, MEM and WB. It generates the registered 2-bit selects that drive the two EX-stage 4:1 operand muxes, and a combinational stall for load-use hazards. It sits between ID decode (upstream) and the operand muxes (downstream).

## Interface
Parameters:
- REG_ADDR_W, 5, register-address width
- CNT_W, 16, width of the stall performance counter

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  REG_ADDR_W  source registers of the ID instruction
- id_use_rs, id_use_rt  in  1  the ID instruction actually reads rs / rt
- id_dest  in  REG_ADDR_W  destination register of the ID instruction
- id_reg_write  in  1  the ID instruction writes id_dest
- id_mem_read  in  1  the ID instruction is a load
- id_a_pc  in  1  operand A takes the PC (link instructions)
- id_b_imm  in  1  operand B takes the immediate
- flush  in  1  branch/jump taken: discard the ID instruction
- stall  out  1  hold PC and IF/ID; combinational
- fwd_a_sel, fwd_b_sel  out  2  operand mux selects for the instruction now in EX; registered
- stall_count  out  CNT_W  saturating count of stall cycles

## Operation
- Three internal slots (EX, MEM, WB). Each slot holds valid, dest, reg_write and mem_read.
- Select encoding: 00 register file, 01 EX/MEM result, 10 MEM/WB result, 11 alternate. The alternate is PC for A and the immediate for B.
- Load-use stall: stall=1 when all of the following hold:
  - id_valid, !flush
  - EX slot is valid, has mem_read and reg_write, and its dest is not 0
  - EX dest equals id_rs with id_use_rs, or equals id_rt with id_use_rt
- Advance on a normal cycle: EX←ID info (valid = id_valid & !flush), MEM←EX, WB←MEM.
- Advance on a stall: EX←bubble (all zero), MEM←EX, WB←MEM.
- Next select for operand A (operand B is identical, using id_rt and id_b_imm):
  - 11 if id_a_pc.
  - Otherwise 01 if the current EX slot is valid, has reg_write, its dest is not 0 and equals id_rs.
  - Otherwise 10 if the current MEM slot meets the same conditions.
  - Otherwise 00.
- Priority: EX-slot match (most recent) beats MEM-slot match.
- Register 0 is never forwarded.
- The WB-slot write is not forwarded; the register file is write-before-read.
- A bubble or flushed instruction loads selects of 00.
- If id_use_rs=0, fwd_a_sel is 00 unless id_a_pc. The same rule applies to B with id_use_rt and id_b_imm.
- stall_count increments on each cycle with stall=1 and saturates at all-ones. It never wraps.

## Timing
- Reset (asynchronous): all slots invalid and zero; fwd_a_sel=fwd_b_sel=00; stall_count=0. stall is therefore 0 while reset is held.
- Selects are registered and valid during the cycle the instruction occupies EX, one clock after it was presented in ID.
- stall is combinational from the ID inputs and the EX slot. Its latency is zero cycles.
- A load-use stall lasts exactly one cycle. On the next cycle the load is in MEM and the dependent instruction is re-presented, getting select 10.
- flush together with a hazard: flush wins. stall=0, a bubble enters EX, and the counter does not increment.
- Reset asserted mid-stall: all state clears immediately. The first cycle after reset release never stalls.

## Structure
- Shared package mips_pkg holds:
  - the FWD_RF/FWD_MEM/FWD_WB/FWD_ALT select constants
  - the slot struct typedef (valid, dest, reg_write, mem_read)
- Sub-module fwd_sel: combinational. It takes one source register, its use flag, the alt flag and the EX and MEM slots, and returns one 2-bit select. It is instantiated twice, once for A and once for B.
- The slot registers, the stall logic and the counter live in forward_ctrl.

## Test plan
- ALU chain: add $3 followed by sub reading $3 as rs → fwd_a_sel=01 in the sub's EX cycle; stall never asserts.
- Two-apart dependency: write $5, an independent instruction, then a reader of $5 as rt → fwd_b_sel=10. With $0 as the destination in the same pattern → 00.
- Load-use: lw $4 followed by add reading $4 as rs → stall=1 for exactly one cycle, a bubble enters EX (selects 00), then fwd_a_sel=10; stall_count increments by 1.
- Double match: EX and MEM slots both write $7 and the reader uses $7 on both operands → fwd_a_sel=fwd_b_sel=01. With id_b_imm=1 → fwd_b_sel=11.
- Flush during a load-use hazard → stall=0, EX slot is a bubble, stall_count is unchanged. Separately, force stall for 2^CNT_W+5 cycles → stall_count holds at all-ones.
- Assert rst asynchronously mid-stall → stall, both selects and stall_count go to 0 before the next clock edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared pipeline definitions: operand-mux select codes, the hazard slot record
// and the slot-match helper used by the forwarding and stall logic.
package mips_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;  // register file
  localparam logic [1:0] FWD_MEM = 2'b01;  // EX/MEM result
  localparam logic [1:0] FWD_WB  = 2'b10;  // MEM/WB result
  localparam logic [1:0] FWD_ALT = 2'b11;  // PC for operand A, immediate for operand B

  // Slot destinations are held at a fixed width so the record can live in the
  // package; narrower register addresses are zero-extended into it.
  localparam int SLOT_DEST_W = 8;

  typedef logic [SLOT_DEST_W-1:0] slot_dest_t;

  typedef struct packed {
    logic       valid;
    slot_dest_t dest;
    logic       reg_write;
    logic       mem_read;
  } slot_t;

  // True when the slot will write a non-zero register equal to src.
  function automatic logic slot_writes(input slot_t s, input slot_dest_t src);
    return s.valid && s.reg_write && (s.dest != '0) && (s.dest == src);
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// Operand-mux select for one EX-stage operand, computed from the ID source
// register against the instructions currently in EX and MEM.
module fwd_sel
  import mips_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  use_src,
  input  logic                  alt,
  input  slot_t                 ex_slot,
  input  slot_t                 mem_slot,
  output logic [1:0]            sel
);

  slot_dest_t src_ext;
  logic       ex_hit;
  logic       mem_hit;
  logic       unused_slot_bits;

  assign src_ext = slot_dest_t'(src);
  assign ex_hit  = use_src && slot_writes(ex_slot, src_ext);
  assign mem_hit = use_src && slot_writes(mem_slot, src_ext);

  // Load-ness only matters to the stall logic in the parent.
  assign unused_slot_bits = ex_slot.mem_read ^ mem_slot.mem_read;

  // The most recent producer wins; the WB stage is covered by the
  // write-before-read register file and is never forwarded.
  always_comb begin
    sel = FWD_RF;
    if (alt) begin
      sel = FWD_ALT;
    end else if (ex_hit) begin
      sel = FWD_MEM;
    end else if (mem_hit) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/forward_ctrl.sv
// EX-stage forwarding and load-use hazard controller: tracks EX/MEM/WB
// destination slots, registers the operand selects and raises a one-cycle stall.
module forward_ctrl
  import mips_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_a_pc,
  input  logic                  id_b_imm,
  input  logic                  flush,
  output logic                  stall,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic [CNT_W-1:0]      stall_count
);

  slot_t            ex_reg;
  slot_t            mem_reg;
  slot_t            wb_reg;
  slot_t            ex_next;
  logic [1:0]       fwd_a_reg;
  logic [1:0]       fwd_b_reg;
  logic [1:0]       fwd_a_next;
  logic [1:0]       fwd_b_next;
  logic [1:0]       sel_a;
  logic [1:0]       sel_b;
  logic [CNT_W-1:0] stall_count_reg;
  logic [CNT_W-1:0] stall_count_next;
  logic             load_hazard;
  logic             stall_int;
  logic             issue;
  logic             unused_wb_slot;
  slot_dest_t       rs_ext;
  slot_dest_t       rt_ext;

  assign rs_ext = slot_dest_t'(id_rs);
  assign rt_ext = slot_dest_t'(id_rt);

  // A load in EX cannot supply its data until MEM, so a reader right behind it
  // has to wait one cycle. A taken branch discards the reader, so flush wins.
  assign load_hazard = ex_reg.mem_read &&
                       ((id_use_rs && slot_writes(ex_reg, rs_ext)) ||
                        (id_use_rt && slot_writes(ex_reg, rt_ext)));
  assign stall_int   = id_valid && !flush && load_hazard;
  assign issue       = id_valid && !flush && !stall_int;

  fwd_sel #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_fwd_a (
    .src     (id_rs),
    .use_src (id_use_rs),
    .alt     (id_a_pc),
    .ex_slot (ex_reg),
    .mem_slot(mem_reg),
    .sel     (sel_a)
  );

  fwd_sel #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_fwd_b (
    .src     (id_rt),
    .use_src (id_use_rt),
    .alt     (id_b_imm),
    .ex_slot (ex_reg),
    .mem_slot(mem_reg),
    .sel     (sel_b)
  );

  always_comb begin
    ex_next    = '0;
    fwd_a_next = FWD_RF;
    fwd_b_next = FWD_RF;
    if (issue) begin
      ex_next.valid     = 1'b1;
      ex_next.dest      = slot_dest_t'(id_dest);
      ex_next.reg_write = id_reg_write;
      ex_next.mem_read  = id_mem_read;
      fwd_a_next        = sel_a;
      fwd_b_next        = sel_b;
    end

    stall_count_next = stall_count_reg;
    if (stall_int && (stall_count_reg != {CNT_W{1'b1}})) begin
      stall_count_next = stall_count_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_reg          <= '0;
      mem_reg         <= '0;
      wb_reg          <= '0;
      fwd_a_reg       <= FWD_RF;
      fwd_b_reg       <= FWD_RF;
      stall_count_reg <= '0;
    end else begin
      ex_reg          <= ex_next;
      mem_reg         <= ex_reg;
      wb_reg          <= mem_reg;
      fwd_a_reg       <= fwd_a_next;
      fwd_b_reg       <= fwd_b_next;
      stall_count_reg <= stall_count_next;
    end
  end

  // The WB slot is tracked for completeness but never forwarded from.
  assign unused_wb_slot = ^wb_reg;

  assign stall       = stall_int;
  assign fwd_a_sel   = fwd_a_reg;
  assign fwd_b_sel   = fwd_b_reg;
  assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_forward_ctrl.sv
// Self-checking bench for forward_ctrl: per-scenario tasks with a queue of
// expected selects compared one cycle after each ID presentation.
module tb_forward_ctrl;
  import mips_pkg::*;

  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 8;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_use_rs;
  logic                  id_use_rt;
  logic [REG_ADDR_W-1:0] id_dest;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  id_a_pc;
  logic                  id_b_imm;
  logic                  flush;
  logic                  stall;
  logic [1:0]            fwd_a_sel;
  logic [1:0]            fwd_b_sel;
  logic [CNT_W-1:0]      stall_count;

  typedef struct {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic [4:0] dest;
    logic       rw;
    logic       mr;
    logic       a_pc;
    logic       b_imm;
    logic       flush;
  } instr_t;

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
  } exp_t;

  typedef struct {
    instr_t     ins;
    logic       stall;
    logic [1:0] a;
    logic [1:0] b;
  } step_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_cnt  = 0;

  forward_ctrl #(
    .REG_ADDR_W(REG_ADDR_W),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .id_dest     (id_dest),
    .id_reg_write(id_reg_write),
    .id_mem_read (id_mem_read),
    .id_a_pc     (id_a_pc),
    .id_b_imm    (id_b_imm),
    .flush       (flush),
    .stall       (stall),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  function automatic instr_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                input logic urs, input logic urt, input logic [4:0] d,
                                input logic rw, input logic mr, input logic apc,
                                input logic bimm, input logic fl);
    instr_t i;
    i.valid = v;  i.rs = rs;  i.rt = rt;  i.use_rs = urs;  i.use_rt = urt;
    i.dest = d;  i.rw = rw;  i.mr = mr;  i.a_pc = apc;  i.b_imm = bimm;  i.flush = fl;
    return i;
  endfunction

  function automatic instr_t idle();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic instr_t alu(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] d);
    return mk(1, rs, rt, 1, 1, d, 1, 0, 0, 0, 0);
  endfunction

  function automatic instr_t ld(input logic [4:0] rs, input logic [4:0] d);
    return mk(1, rs, 0, 1, 0, d, 1, 1, 0, 0, 0);
  endfunction

  function automatic step_t st(input instr_t i, input logic s, input logic [1:0] a, input logic [1:0] b);
    step_t r;
    r.ins = i;  r.stall = s;  r.a = a;  r.b = b;
    return r;
  endfunction

  task automatic drive(input instr_t i);
    id_valid     = i.valid;
    id_rs        = i.rs;
    id_rt        = i.rt;
    id_use_rs    = i.use_rs;
    id_use_rt    = i.use_rt;
    id_dest      = i.dest;
    id_reg_write = i.rw;
    id_mem_read  = i.mr;
    id_a_pc      = i.a_pc;
    id_b_imm     = i.b_imm;
    flush        = i.flush;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(alu(4, 4, 4));
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall); end
    n_checks++;
    if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
      n_fail++; $display("FAIL reset_sel got %b/%b want 00/00", fwd_a_sel, fwd_b_sel);
    end
    n_checks++;
    if (stall_count !== '0) begin n_fail++; $display("FAIL reset_count got %0d want 0", stall_count); end
    drive(idle());
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_alu_chain();
    step_t s[$];
    exp_t  e;
    s.push_back(st(idle(), 0, FWD_RF, FWD_RF));
    s.push_back(st(idle(), 0, FWD_RF, FWD_RF));
    s.push_back(st(alu(1, 2, 3), 0, FWD_RF, FWD_RF));
    s.push_back(st(alu(3, 1, 6), 0, FWD_MEM, FWD_RF));
    s.push_back(st(alu(1, 3, 7), 0, FWD_RF, FWD_WB));
    s.push_back(st(idle(), 0, FWD_RF, FWD_RF));
    foreach (s[k]) begin
      drive(s[k].ins);
      #1;
      n_checks++;
      if (stall !== s[k].stall) begin n_fail++; $display("FAIL alu_chain_stall step %0d got %b want %b", k, stall, s[k].stall); end
      sb.push_back('{a: s[k].a, b: s[k].b});
      if (s[k].stall && exp_cnt < CNT_MAX) exp_cnt++;
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_checks++;
      if (fwd_a_sel !== e.a) begin n_fail++; $display("FAIL alu_chain_a step %0d got %b want %b", k, fwd_a_sel, e.a); end
      n_checks++;
      if (fwd_b_sel !== e.b) begin n_fail++; $display("FAIL alu_chain_b step %0d got %b want %b", k, fwd_b_sel, e.b); end
      n_checks++;
      if (stall_count !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL alu_chain_cnt step %0d got %0d want %0d", k, stall_count, exp_cnt); end
    end
  endtask

  task automatic test_two_apart();
    step_t s[$];
    exp_t  e;
    s.push_back(st(idle(), 0, FWD_RF, FWD_RF));
    s.push_back(st(idle(), 0, FWD_RF, FWD_RF));
    s.push_back(st(alu(1, 2, 5), 0, FWD_RF, FWD_RF));
    s.push_back(st(alu(8, 9, 10), 0, FWD_RF, FWD_RF));
    s.push_back(st(alu(1, 5, 11), 0, FWD_RF, FWD_WB));
    s.push_back(st(alu(1, 2, 0), 0, FWD_RF, FWD_RF));
    s.push_back(st(alu(8, 9, 10), 0, FWD_RF, FWD_RF));
    s.push_back(st(alu(1, 0, 11), 0, FWD_RF, FWD_RF));
    s.push_back(st(mk(1, 1, 2, 1, 1, 12, 0, 0, 0, 0, 0), 0, FWD_RF, FWD_RF));
    s.push_back(st(alu(12, 2, 13), 0, FWD_RF, FWD_RF));
    foreach (s[k]) begin
      drive(s[k].ins);
      #1;
      n_checks++;
      if (stall !== s[k].stall) begin n_fail++; $display("FAIL two_apart_stall step %0d got %b want %b", k, stall, s[k].stall); end
      sb.push_back('{a: s[k].a, b: s[k].b});
      if (s[k].stall && exp_cnt < CNT_MAX) exp_cnt++;
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_checks++;
      if (fwd_a_sel !== e.a) begin n_fail++; $display("FAIL two_apart_a step %0d got %b want %b", k, fwd_a_sel, e.a); end
      n_checks++;
      if (fwd_b_sel !== e.b) begin n_fail++; $display("FAIL two_apart_b step %0d got %b want %b", k, fwd_b_sel, e.b); end
    end
  endtask

  task automatic test_load_use();
    step_t s[$];
    exp_t  e;
    s.push_back(st(idle(), 0, FWD_RF, FWD_RF));
    s.push_back(st(idle(), 0, FWD_RF, FWD_RF));
    s.push_back(st(ld(1, 4), 0, FWD_RF, FWD_RF));
    s.push_back(st(alu(4, 2, 5), 1, FWD_RF, FWD_RF));
    s.push_back(st(alu(4, 2, 5), 0, FWD_WB, FWD_RF));
    s.push_back(st(ld(1, 0), 0, FWD_RF, FWD_RF));
    s.push_back(st(alu(0, 5, 6), 0, FWD_RF, FWD_WB));
    s.push_back(st(ld(1, 4), 0, FWD_RF, FWD_RF));
    s.push_back(st(mk(1, 4, 4, 0, 0, 7, 1, 0, 0, 0, 0), 0, FWD_RF, FWD_RF));
    s.push_back(st(ld(1, 9), 0, FWD_RF, FWD_RF));
    s.push_back(st(alu(2, 9, 3), 1, FWD_RF, FWD_RF));
    s.push_back(st(alu(2, 9, 3), 0, FWD_RF, FWD_WB));
    s.push_back(st(idle(), 0, FWD_RF, FWD_RF));
    foreach (s[k]) begin
      drive(s[k].ins);
      #1;
      n_checks++;
      if (stall !== s[k].stall) begin n_fail++; $display("FAIL load_use_stall step %0d got %b want %b", k, stall, s[k].stall); end
      sb.push_back('{a: s[k].a, b: s[k].b});
      if (s[k].stall && exp_cnt < CNT_MAX) exp_cnt++;
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_checks++;
      if (fwd_a_sel !== e.a) begin n_fail++; $display("FAIL load_use_a step %0d got %b want %b", k, fwd_a_sel, e.a); end
      n_checks++;
      if (fwd_b_sel !== e.b) begin n_fail++; $display("FAIL load_use_b step %0d got %b want %b", k, fwd_b_sel, e.b); end
      n_checks++;
      if (stall_count !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL load_use_cnt step %0d got %0d want %0d", k, stall_count, exp_cnt); end
    end
  endtask

  task automatic test_double_match();
    step_t s[$];
    exp_t  e;
    s.push_back(st(idle(), 0, FWD_RF, FWD_RF));
    s.push_back(st(idle(), 0, FWD_RF, FWD_RF));
    s.push_back(st(alu(1, 2, 7), 0, FWD_RF, FWD_RF));
    s.push_back(st(alu(3, 4, 7), 0, FWD_RF, FWD_RF));
    s.push_back(st(alu(7, 7, 8), 0, FWD_MEM, FWD_MEM));
    s.push_back(st(alu(1, 2, 7), 0, FWD_RF, FWD_RF));
    s.push_back(st(alu(3, 4, 7), 0, FWD_RF, FWD_RF));
    s.push_back(st(mk(1, 7, 7, 1, 1, 8, 1, 0, 0, 1, 0), 0, FWD_MEM, FWD_ALT));
    s.push_back(st(mk(1, 7, 7, 1, 1, 9, 1, 0, 1, 0, 0), 0, FWD_ALT, FWD_WB));
    s.push_back(st(mk(0, 7, 7, 1, 1, 9, 1, 0, 1, 1, 0), 0, FWD_RF, FWD_RF));
    foreach (s[k]) begin
      drive(s[k].ins);
      #1;
      n_checks++;
      if (stall !== s[k].stall) begin n_fail++; $display("FAIL double_match_stall step %0d got %b want %b", k, stall, s[k].stall); end
      sb.push_back('{a: s[k].a, b: s[k].b});
      if (s[k].stall && exp_cnt < CNT_MAX) exp_cnt++;
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_checks++;
      if (fwd_a_sel !== e.a) begin n_fail++; $display("FAIL double_match_a step %0d got %b want %b", k, fwd_a_sel, e.a); end
      n_checks++;
      if (fwd_b_sel !== e.b) begin n_fail++; $display("FAIL double_match_b step %0d got %b want %b", k, fwd_b_sel, e.b); end
    end
  endtask

  task automatic test_flush();
    step_t s[$];
    exp_t  e;
    s.push_back(st(idle(), 0, FWD_RF, FWD_RF));
    s.push_back(st(idle(), 0, FWD_RF, FWD_RF));
    s.push_back(st(ld(1, 4), 0, FWD_RF, FWD_RF));
    s.push_back(st(mk(1, 4, 2, 1, 1, 11, 1, 0, 1, 0, 1), 0, FWD_RF, FWD_RF));
    s.push_back(st(alu(11, 4, 12), 0, FWD_RF, FWD_WB));
    s.push_back(st(idle(), 0, FWD_RF, FWD_RF));
    foreach (s[k]) begin
      drive(s[k].ins);
      #1;
      n_checks++;
      if (stall !== s[k].stall) begin n_fail++; $display("FAIL flush_stall step %0d got %b want %b", k, stall, s[k].stall); end
      sb.push_back('{a: s[k].a, b: s[k].b});
      if (s[k].stall && exp_cnt < CNT_MAX) exp_cnt++;
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_checks++;
      if (fwd_a_sel !== e.a) begin n_fail++; $display("FAIL flush_a step %0d got %b want %b", k, fwd_a_sel, e.a); end
      n_checks++;
      if (fwd_b_sel !== e.b) begin n_fail++; $display("FAIL flush_b step %0d got %b want %b", k, fwd_b_sel, e.b); end
      n_checks++;
      if (stall_count !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL flush_cnt step %0d got %0d want %0d", k, stall_count, exp_cnt); end
    end
  endtask

  // Holding a self-dependent load in ID stalls on every other cycle.
  task automatic test_saturation();
    int   stalls = 0;
    logic exp_stall;
    drive(idle());
    repeat (2) @(posedge clk);
    #1;
    drive(ld(4, 4));
    for (int c = 0; stalls < CNT_MAX + 6; c++) begin
      exp_stall = c[0];
      #1;
      n_checks++;
      if (stall !== exp_stall) begin n_fail++; $display("FAIL sat_stall cycle %0d got %b want %b", c, stall, exp_stall); end
      if (exp_stall) begin
        stalls++;
        if (exp_cnt < CNT_MAX) exp_cnt++;
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (stall_count !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL sat_cnt cycle %0d got %0d want %0d", c, stall_count, exp_cnt); end
    end
    n_checks++;
    if (stall_count !== {CNT_W{1'b1}}) begin n_fail++; $display("FAIL sat_final got %0d want %0d", stall_count, CNT_MAX); end
    drive(idle());
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_stall();
    drive(alu(1, 2, 6));
    @(posedge clk);
    #1;
    drive(ld(6, 4));
    @(posedge clk);
    #1;
    drive(alu(4, 2, 9));
    #1;
    n_checks++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre_stall got %b want 1", stall); end
    n_checks++;
    if (fwd_a_sel !== FWD_MEM) begin n_fail++; $display("FAIL rst_mid_pre_a got %b want 01", fwd_a_sel); end
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall got %b want 0", stall); end
    n_checks++;
    if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
      n_fail++; $display("FAIL rst_mid_sel got %b/%b want 00/00", fwd_a_sel, fwd_b_sel);
    end
    n_checks++;
    if (stall_count !== '0) begin n_fail++; $display("FAIL rst_mid_cnt got %0d want 0", stall_count); end
    sb.delete();
    exp_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_release_stall got %b want 0", stall); end
    @(posedge clk);
    #1;
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_post_stall got %b want 0", stall); end
    n_checks++;
    if (stall_count !== '0) begin n_fail++; $display("FAIL rst_post_cnt got %0d want 0", stall_count); end
  endtask

  initial begin
    test_reset();
    test_alu_chain();
    test_two_apart();
    test_load_use();
    test_double_match();
    test_flush();
    test_saturation();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
